// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A buffer entry packs the fetch address above the instruction word.
package busca_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic int entry_w(input int addr_w);
        return addr_w + INSTR_W;
    endfunction

endpackage

// File: rtl/unidade_de_busca_fila.sv
// Prefetch FIFO built as a shift register so the head is always entry 0.
// Vacated and flushed slots are zeroed, which makes the head read 0 when empty.
module fila_de_instrucoes #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] entries_q, entries_d;
    logic [CW-1:0]               count_q, count_d;
    logic [CW-1:0]               wr_idx;
    logic                        pop_eff;

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        pop_eff   = pop && (count_q != '0);
        wr_idx    = count_q - CW'(pop_eff);
        if (flush) begin
            entries_d = '0;
            count_d   = '0;
        end else begin
            if (pop_eff) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entries_d[i] = entries_q[i+1];
                end
                entries_d[DEPTH-1] = '0;
            end
            // On a simultaneous pop the tail slot has already shifted down by one.
            if (push && (wr_idx < CW'(DEPTH))) begin
                entries_d[wr_idx[IW-1:0]] = din;
            end
            count_d = count_q + CW'(push) - CW'(pop_eff);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    assign head  = entries_q[0];
    assign count = count_q;

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch stage: PC, one outstanding read to a synchronous memory,
// and a prefetch FIFO offered to the processor through valid/take.
module unidade_de_busca
    import busca_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] iin,
    output logic               iin_valid,
    input  logic               iin_take,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    input  logic               halt,
    output state_t             state_dbg
);

    // Handshake: a head entry is consumed on a cycle where iin_valid and iin_take
    // are both 1; iin_valid never depends on iin_take in the same cycle.
    localparam int EW = entry_w(ADDR_W);
    localparam int CW = $clog2(DEPTH + 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]       count;
    logic [EW-1:0]       head;
    logic                take;
    logic                has_room;

    assign take     = iin_take && iin_valid;
    // Space is reserved for the in-flight read so a return can never overflow.
    assign has_room = (int'(count) + int'(inflight_q)) < (DEPTH + int'(take));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_RUN;
            ST_RUN:    state_d = halt ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = halt ? ST_HALTED : ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd = (state_q == ST_RUN) && !halt && !pc_load && has_room;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = mem_rd;
        inflight_pc_d = inflight_pc_q;
        if (pc_load) begin
            fetch_pc_d = pc_target;
        end else if (mem_rd) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fila_de_instrucoes #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fila (
        .clock (clock),
        .reset (reset),
        .push  (inflight_q && !pc_load),
        .pop   (take),
        .flush (pc_load),
        .din   ({inflight_pc_q, mem_data}),
        .head  (head),
        .count (count)
    );

    assign mem_addr  = fetch_pc_q;
    assign iin_valid = (count != '0);
    assign iin       = head[INSTR_W-1:0];
    assign pc_out    = head[EW-1:INSTR_W];
    assign state_dbg = state_q;

endmodule
